// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci analyzer: ALU opcodes and sequencer states.
package fib_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } fib_state_t;

endpackage

// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequencer: steps terms through the shared ALU (ADD for the next
// term, SUB to compare each term with the target) and streams every term out.
module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  output logic             busy,
  output logic             term_valid,
  output logic [WIDTH-1:0] term_value,
  output logic [IDX_W-1:0] term_index,
  output logic             done,
  output logic             found,
  output logic             overflow,
  output logic [IDX_W-1:0] result_index,
  output logic [WIDTH-1:0] alu_left,
  output logic [WIDTH-1:0] alu_right,
  output logic             alu_status_in,
  output logic [1:0]       alu_opcode,
  input  logic             alu_status_out,
  input  logic [WIDTH-1:0] alu_result
);

  fib_state_t       state, state_nxt;
  logic [WIDTH-1:0] a, b, tgt;
  logic [IDX_W-1:0] idx;
  logic             b_ovf;

  // State register; reset aborts any run straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and ALU/stream outputs, all derived from the current state.
  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    term_valid    = 1'b0;
    term_value    = '0;
    term_index    = '0;
    done          = 1'b0;
    alu_left      = '0;
    alu_right     = '0;
    alu_status_in = 1'b0;
    alu_opcode    = OP_OR;
    case (state)
      IDLE: begin
        if (start) state_nxt = CMP;
      end
      CMP: begin
        busy       = 1'b1;
        term_valid = 1'b1;
        term_value = a;
        term_index = idx;
        alu_opcode = OP_SUB;
        alu_left   = tgt;
        alu_right  = a;
        if (alu_result == '0)  state_nxt = DONE;
        else if (alu_status_out) state_nxt = DONE;
        else                     state_nxt = STEP;
      end
      STEP: begin
        busy       = 1'b1;
        alu_opcode = OP_ADD;
        alu_left   = a;
        alu_right  = b;
        state_nxt  = b_ovf ? DONE : CMP;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Term registers and held results. A wrapped b only ends the run once it
  // would become the current term, so the last valid a is still compared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a            <= '0;
      b            <= '0;
      tgt          <= '0;
      idx          <= '0;
      b_ovf        <= 1'b0;
      found        <= 1'b0;
      overflow     <= 1'b0;
      result_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tgt          <= target;
            a            <= '0;
            b            <= WIDTH'(1);
            idx          <= '0;
            b_ovf        <= 1'b0;
            found        <= 1'b0;
            overflow     <= 1'b0;
            result_index <= '0;
          end
        end
        CMP: begin
          result_index <= idx;
          if (alu_result == '0) found <= 1'b1;
        end
        STEP: begin
          if (b_ovf) begin
            overflow <= 1'b1;
          end else begin
            a     <= b;
            b     <= alu_result;
            b_ovf <= alu_status_out;
            idx   <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl with a behavioural 8-bit ALU attached.
module tb_fib_seq_ctrl;
  import fib_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] target;
  logic       busy, term_valid, done, found, overflow;
  logic [7:0] term_value;
  logic [4:0] term_index, result_index;
  logic [7:0] alu_left, alu_right, alu_result;
  logic       alu_status_in, alu_status_out;
  logic [1:0] alu_opcode;
  logic [8:0] alu_full;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fib_tab [0:13] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8,
                                 8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};

  fib_seq_ctrl #(.WIDTH(8), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
    .busy(busy), .term_valid(term_valid), .term_value(term_value),
    .term_index(term_index), .done(done), .found(found), .overflow(overflow),
    .result_index(result_index), .alu_left(alu_left), .alu_right(alu_right),
    .alu_status_in(alu_status_in), .alu_opcode(alu_opcode),
    .alu_status_out(alu_status_out), .alu_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference alu8 behaviour.
  always_comb begin
    alu_full = '0;
    case (alu_opcode)
      OP_ADD:  alu_full = {1'b0, alu_left} + {1'b0, alu_right} + {8'd0, alu_status_in};
      OP_SUB:  alu_full = {1'b0, alu_left} - {1'b0, alu_right} - {8'd0, alu_status_in};
      OP_AND:  alu_full = {1'b0, alu_left & alu_right};
      default: alu_full = {1'b0, alu_left | alu_right};
    endcase
    alu_result     = alu_full[7:0];
    alu_status_out = alu_full[8];
  end

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({busy, term_valid, done, found, overflow} !== 5'b0 ||
        term_value !== 8'd0 || term_index !== 5'd0 || result_index !== 5'd0) begin
      n_bad++;
      $display("FAIL %s outputs: busy=%b tv=%b done=%b found=%b ovf=%b val=%0d idx=%0d ri=%0d, required all 0",
               name, busy, term_valid, done, found, overflow, term_value, term_index, result_index);
    end
    n_cmp++;
    if (alu_opcode !== OP_OR || alu_left !== 8'd0 || alu_right !== 8'd0 || alu_status_in !== 1'b0) begin
      n_bad++;
      $display("FAIL %s alu lines: op=%0d l=%0d r=%0d cin=%b, required op=3 l=0 r=0 cin=0",
               name, alu_opcode, alu_left, alu_right, alu_status_in);
    end
  endtask

  // Runs one request; glitch_cyc>0 pulses start (with another target) in that cycle.
  task automatic run_target(input string name, input logic [7:0] t, input int k_end,
                            input logic exp_found, input logic exp_ovf,
                            input int exp_done_cyc, input int glitch_cyc);
    logic [7:0] vals [$];
    logic [4:0] idxs [$];
    int   done_cyc;
    logic f_s, o_s;
    logic [4:0] ri_s;
    done_cyc = -1;
    f_s = 1'b0; o_s = 1'b0; ri_s = '0;
    target = t;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc == 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL %s busy_c1: got %b, required 1", name, busy);
        end
      end
      if (term_valid === 1'b1) begin
        vals.push_back(term_value);
        idxs.push_back(term_index);
        n_cmp++;
        if (alu_opcode !== OP_SUB || alu_left !== t || alu_right !== term_value || alu_status_in !== 1'b0) begin
          n_bad++;
          $display("FAIL %s cmp_alu c%0d: op=%0d l=%0d r=%0d cin=%b, required op=1 l=%0d r=%0d cin=0",
                   name, cyc, alu_opcode, alu_left, alu_right, alu_status_in, t, term_value);
        end
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        f_s = found; o_s = overflow; ri_s = result_index;
        break;
      end
      if (cyc == glitch_cyc) begin
        start  = 1'b1;
        target = 8'd4;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;

    n_cmp++;
    if (done_cyc < 0) begin
      n_bad++;
      $display("FAIL %s timeout: no done within 60 cycles, required done", name);
      return;
    end
    n_cmp++;
    if (vals.size() != k_end + 1) begin
      n_bad++;
      $display("FAIL %s term_count: got %0d, required %0d", name, vals.size(), k_end + 1);
    end
    for (int i = 0; i < vals.size() && i <= 13; i++) begin
      n_cmp++;
      if (vals[i] !== fib_tab[i] || idxs[i] !== 5'(i)) begin
        n_bad++;
        $display("FAIL %s term%0d: got %0d idx %0d, required %0d idx %0d",
                 name, i, vals[i], idxs[i], fib_tab[i], i);
      end
    end
    if (exp_done_cyc >= 0) begin
      n_cmp++;
      if (done_cyc != exp_done_cyc) begin
        n_bad++;
        $display("FAIL %s done_cycle: got %0d, required %0d", name, done_cyc, exp_done_cyc);
      end
    end
    n_cmp++;
    if (f_s !== exp_found || o_s !== exp_ovf || ri_s !== 5'(k_end)) begin
      n_bad++;
      $display("FAIL %s result: found=%b ovf=%b ri=%0d, required found=%b ovf=%b ri=%0d",
               name, f_s, o_s, ri_s, exp_found, exp_ovf, k_end);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || found !== exp_found || overflow !== exp_ovf) begin
      n_bad++;
      $display("FAIL %s after_done: done=%b busy=%b found=%b ovf=%b, required 0 0 %b %b",
               name, done, busy, found, overflow, exp_found, exp_ovf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; target = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("idle");
  endtask

  task automatic test_found();
    run_target("t0", 8'd0, 0, 1'b1, 1'b0, 2, 0);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (found !== 1'b1 || result_index !== 5'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_t0: found=%b ri=%0d busy=%b, required 1 0 0", found, result_index, busy);
    end
    run_target("t13", 8'd13, 7, 1'b1, 1'b0, 16, 0);
  endtask

  task automatic test_not_found();
    run_target("t4", 8'd4, 5, 1'b0, 1'b0, 12, 0);
  endtask

  task automatic test_boundary();
    run_target("t233", 8'd233, 13, 1'b1, 1'b0, 28, 0);
    run_target("t255", 8'd255, 13, 1'b0, 1'b1, -1, 0);
  endtask

  task automatic test_start_while_busy();
    run_target("glitch", 8'd13, 7, 1'b1, 1'b0, 16, 5);
  endtask

  task automatic test_reset_mid_run();
    int saw_done;
    saw_done = 0;
    target = 8'd13;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1 || term_valid !== 1'b0 || alu_opcode !== OP_ADD) begin
      n_bad++;
      $display("FAIL midrun_pre: busy=%b tv=%b op=%0d, required 1 0 0", busy, term_valid, alu_opcode);
    end
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done++;
    end
    n_cmp++;
    if (saw_done != 0) begin
      n_bad++;
      $display("FAIL midrun_done: got %0d done pulses, required 0", saw_done);
    end
    run_target("after_reset", 8'd13, 7, 1'b1, 1'b0, 16, 0);
  endtask

  initial begin
    test_reset();
    test_found();
    test_not_found();
    test_boundary();
    test_start_while_busy();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fib_seq_ctrl.md
# fib_seq_ctrl

Sequencer that drives the shared 8-bit combinational ALU (`alu8`) to generate Fibonacci terms F0, F1, F2, … and decide whether a requested target value is a Fibonacci number. It owns the ALU operand and opcode lines, uses ADD to produce the next term and SUB to compare each term with the target, and streams every generated term out. It sits between the analyzer's command interface and `alu8`; `fib_analyzer_top` wires the two together.

## Interface

- `WIDTH`, 8, data width; must equal the `alu8` width.
- `IDX_W`, 5, width of the term index.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request pulse; sampled only in IDLE.
- `target`  in  WIDTH  value to test; captured when `start` is accepted.
- `busy`  out  1  high in CMP and STEP.
- `term_valid`  out  1  one-cycle strobe per generated term.
- `term_value`  out  WIDTH  term, valid with `term_valid`.
- `term_index`  out  IDX_W  k of F(k), valid with `term_valid`.
- `done`  out  1  one-cycle pulse at end of run.
- `found`  out  1  target is a Fibonacci number; held until next accepted `start`.
- `overflow`  out  1  run ended because the next term exceeded 2^WIDTH-1; held.
- `result_index`  out  IDX_W  index of the last term compared; held.
- `alu_left`, `alu_right`  out  WIDTH  ALU operands.
- `alu_status_in`  out  1  ALU carry/borrow in; always 0.
- `alu_opcode`  out  2  ADD=0, SUB=1, AND=2, OR=3.
- `alu_status_out`  in  1  ALU carry-out (ADD) or borrow-out (SUB).
- `alu_result`  in  WIDTH  ALU result.

## Operation

**ALU contract.**
- ADD: result = left + right + status_in, mod 2^WIDTH; status_out = carry.
- SUB: result = left − right − status_in, mod 2^WIDTH; status_out = 1 when left < right + status_in.

**Registers.**
- `a` (current term), `b` (next term), `idx`, `tgt`.
- `b_ovf`: set when `b` has wrapped.

**States.**
- IDLE:
  - ALU driven with OR, 0, 0.
  - On `start`: `tgt←target`, `a←0`, `b←1`, `idx←0`, `b_ovf←0`; clear `found`, `overflow` and `result_index`; go to CMP.
- CMP:
  - ALU driven with SUB, left=`tgt`, right=`a`.
  - `term_valid=1`, `term_value=a`, `term_index=idx`, `result_index←idx`.
  - If `alu_result==0`: `found←1` and go to DONE.
  - Else if `alu_status_out==1` (target < a): go to DONE with `found=0`.
  - Else: go to STEP.
- STEP:
  - ALU driven with ADD, left=`a`, right=`b`.
  - If `b_ovf==1`: `overflow←1` and go to DONE; registers are unchanged.
  - Else: `a←b`, `b←alu_result`, `b_ovf←alu_status_out`, `idx←idx+1`, and go to CMP.
- DONE:
  - `done=1` for one cycle, then go to IDLE.
  - `start` is ignored in this state.

**Rules.**
- `start` is ignored in CMP, STEP and DONE. `target` changes during a run have no effect.
- `b_ovf` set in STEP does not by itself end the run. The valid `a` (the old `b`) is still emitted and compared, so target=233 is found.
- The index never exceeds 13 at WIDTH=8. `idx` is not allowed to wrap.

**Reset.**
- `rst_n` low at any time, including mid-run, forces IDLE immediately.
- All outputs go to 0; the ALU lines go to OR, 0, 0.
- No `done` is generated for the aborted run.

## Timing

- ALU path is combinational: the `alu_*` outputs are decoded from state and registers, and `alu_result`/`alu_status_out` are consumed in the same cycle.
- `start` accepted at edge 0. CMP for F(k) occupies cycle 2k+1. STEP cycles are 2k+2.
- `done` for a run ending at index k is high in cycle 2k+2.
- `found`, `overflow` and `result_index` are valid from the `done` cycle until the next accepted `start`.
- Throughput: one term per 2 cycles.
- The earliest next `start` is accepted in the cycle after `done`.

## Structure

- Package `fib_pkg` holds:
  - `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`, shared with `alu8` and its bench;
  - the state enum `fib_state_t` (IDLE, CMP, STEP, DONE).
- `fib_seq_ctrl` is a single module: FSM plus registers, with no sub-modules. The `alu8` instance lives in `fib_analyzer_top`.

## Test plan

- **target=0:** one `term_valid` (0, idx 0) in cycle 1; `done` in cycle 2; `found=1`, `result_index=0`, `overflow=0`.
- **target=13:** terms 0,1,1,2,3,5,8,13 with idx 0–7; `done` in cycle 16; `found=1`, `result_index=7`.
- **target=4:** terms 0,1,1,2,3,5; stops at 5; `found=0`, `result_index=5`, `overflow=0`.
- **target=233:** found at idx 13 although the preceding STEP carried; `overflow=0`.
- **target=255:** terms through 233 (idx 13); `found=0`, `overflow=1`, `result_index=13`; no term 121 is ever emitted.
- **Robustness:**
  - `start` pulsed while `busy` is ignored, and the run completes unchanged.
  - `rst_n` low during STEP: all outputs are 0 immediately and there is no `done`.
  - A new `start` after release runs cleanly.
